regfile_snapshot: RTL and testbench

Snapshot reader for the RV32 register file. On request it sweeps all GPRs through the file's three combinational read ports, three registers per cycle, into an internal buffer. It then streams the captured values out one per valid/ready beat with register index and last flag. It sits beside the register file as its read-side client for the memo/trace path.

---
 rtl/regfile_pkg.sv | 18 +
 rtl/regfile_snapshot.sv | 128 ++++++++++++
 tb/tb_regfile_snapshot.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file snapshot reader.
package regfile_pkg;

    localparam int XLEN   = 32;
    localparam int NUMREG = 32;

    localparam int SNAP_READS_PER_CYC  = 3;
    localparam int SNAP_CAPTURE_CYCLES = 11;

    typedef logic [4:0] reg_idx_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        STREAM  = 2'd2
    } snap_state_e;

endpackage

// File: rtl/regfile_snapshot.sv
// Sweeps all GPRs through three read ports into a local buffer, then streams
// them out one per valid/ready beat with index and last flag.
module regfile_snapshot
    import regfile_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            snap_req,
    output logic            snap_busy,
    output logic            stall_wr,
    output logic            snap_done,
    output logic [4:0]      ra0,
    output logic [4:0]      ra1,
    output logic [4:0]      ra2,
    input  logic [XLEN-1:0] rd0,
    input  logic [XLEN-1:0] rd1,
    input  logic [XLEN-1:0] rd2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic [4:0]      out_idx,
    output logic            out_last
);

    localparam reg_idx_t LAST_CBASE =
        reg_idx_t'((SNAP_CAPTURE_CYCLES - 1) * SNAP_READS_PER_CYC);
    localparam reg_idx_t LAST_IDX = reg_idx_t'(NUMREG - 1);

    snap_state_e state_q, state_d;
    reg_idx_t    cbase_q, cbase_d;
    reg_idx_t    out_idx_q, out_idx_d;
    logic        done_q, done_d;

    logic [XLEN-1:0] snap_buf_q [NUMREG];
    logic [XLEN-1:0] snap_buf_d [NUMREG];

    // Slot indices are one bit wider so the overflow past x31 is visible.
    logic [5:0]      slot   [SNAP_READS_PER_CYC];
    logic            slot_ok[SNAP_READS_PER_CYC];
    logic [XLEN-1:0] rd_arr [SNAP_READS_PER_CYC];
    reg_idx_t        ra_arr [SNAP_READS_PER_CYC];

    assign rd_arr[0] = rd0;
    assign rd_arr[1] = rd1;
    assign rd_arr[2] = rd2;

    generate
        for (genvar gi = 0; gi < SNAP_READS_PER_CYC; gi++) begin : g_slot
            assign slot[gi]    = {1'b0, cbase_q} + 6'(gi);
            assign slot_ok[gi] = slot[gi] < 6'(NUMREG);
            assign ra_arr[gi]  = (state_q == CAPTURE && slot_ok[gi]) ? slot[gi][4:0] : '0;
        end
    endgenerate

    assign ra0 = ra_arr[0];
    assign ra1 = ra_arr[1];
    assign ra2 = ra_arr[2];

    assign snap_busy = (state_q != IDLE);
    assign stall_wr  = (state_q == CAPTURE);
    assign snap_done = done_q;
    assign out_valid = (state_q == STREAM);
    assign out_idx   = out_idx_q;
    assign out_last  = out_valid && (out_idx_q == LAST_IDX);
    assign out_data  = out_valid ? snap_buf_q[out_idx_q] : '0;

    always_comb begin
        state_d    = state_q;
        cbase_d    = cbase_q;
        out_idx_d  = out_idx_q;
        done_d     = 1'b0;
        snap_buf_d = snap_buf_q;
        case (state_q)
            IDLE: begin
                if (snap_req) begin
                    state_d = CAPTURE;
                    cbase_d = '0;
                end
            end
            CAPTURE: begin
                for (int k = 0; k < SNAP_READS_PER_CYC; k++) begin
                    if (slot_ok[k]) begin
                        snap_buf_d[slot[k][4:0]] = rd_arr[k];
                    end
                end
                if (cbase_q == LAST_CBASE) begin
                    state_d   = STREAM;
                    cbase_d   = '0;
                    out_idx_d = '0;
                end else begin
                    cbase_d = cbase_q + reg_idx_t'(SNAP_READS_PER_CYC);
                end
            end
            STREAM: begin
                if (out_ready) begin
                    if (out_idx_q == LAST_IDX) begin
                        state_d   = IDLE;
                        out_idx_d = '0;
                        done_d    = 1'b1;
                    end else begin
                        out_idx_d = out_idx_q + 5'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cbase_q   <= '0;
            out_idx_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cbase_q   <= cbase_d;
            out_idx_q <= out_idx_d;
            done_q    <= done_d;
        end
    end

    // Buffer contents are don't-care outside STREAM, so they carry no reset.
    always_ff @(posedge clk) begin
        snap_buf_q <= snap_buf_d;
    end

endmodule

// File: tb/tb_regfile_snapshot.sv
// Directed bench for regfile_snapshot with a behavioural register file model.
module tb_regfile_snapshot;

    logic        clk;
    logic        rst;
    logic        snap_req;
    logic        snap_busy;
    logic        stall_wr;
    logic        snap_done;
    logic [4:0]  ra0, ra1, ra2;
    logic [31:0] rd0, rd1, rd2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_idx;
    logic        out_last;

    logic [31:0] rf     [32];
    logic [31:0] exp_rf [32];

    int checks = 0;
    int errors = 0;

    assign rd0 = rf[ra0];
    assign rd1 = rf[ra1];
    assign rd2 = rf[ra2];

    regfile_snapshot dut (
        .clk       (clk),
        .rst       (rst),
        .snap_req  (snap_req),
        .snap_busy (snap_busy),
        .stall_wr  (stall_wr),
        .snap_done (snap_done),
        .ra0       (ra0),
        .ra1       (ra1),
        .ra2       (ra2),
        .rd0       (rd0),
        .rd1       (rd1),
        .rd2       (rd2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  32'(snap_busy), 32'd0);
        check({tag, "_stall"}, 32'(stall_wr),  32'd0);
        check({tag, "_done"},  32'(snap_done), 32'd0);
        check({tag, "_ra"},    32'({ra0, ra1, ra2}), 32'd0);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_data"},  out_data, 32'd0);
        check({tag, "_idx"},   32'(out_idx), 32'd0);
        check({tag, "_last"},  32'(out_last), 32'd0);
    endtask

    // Accept edge t0; the snapshot image is the register file at this point.
    task automatic start_snapshot(input bit hold_req);
        for (int i = 0; i < 32; i++) exp_rf[i] = rf[i];
        check("pre_stall", 32'(stall_wr), 32'd0);
        snap_req = 1'b1;
        step();
        if (!hold_req) snap_req = 1'b0;
    endtask

    task automatic run_capture();
        for (int c = 0; c < 11; c++) begin
            check("cap_ra0",   32'(ra0), 32'(3 * c));
            check("cap_ra1",   32'(ra1), 32'(3 * c + 1));
            check("cap_ra2",   32'(ra2), (3 * c + 2 < 32) ? 32'(3 * c + 2) : 32'd0);
            check("cap_stall", 32'(stall_wr), 32'd1);
            check("cap_busy",  32'(snap_busy), 32'd1);
            check("cap_valid", 32'(out_valid), 32'd0);
            step();
        end
    endtask

    task automatic run_stream(input bit toggle, input bit do_write);
        int  beat = 0;
        int  cyc  = 0;
        logic rdy;
        while (beat < 32 && cyc < 200) begin
            if (do_write && beat == 2) rf[5] = 32'hDEAD_BEEF;
            check("st_valid", 32'(out_valid), 32'd1);
            check("st_idx",   32'(out_idx), 32'(beat));
            check("st_data",  out_data, exp_rf[beat]);
            check("st_last",  32'(out_last), (beat == 31) ? 32'd1 : 32'd0);
            check("st_stall", 32'(stall_wr), 32'd0);
            check("st_done",  32'(snap_done), 32'd0);
            rdy = toggle ? ((cyc % 2) == 0) : 1'b1;
            out_ready = rdy;
            $display("beat %0d cyc %0d ready %0d idx %0d data %h", beat, cyc, rdy, out_idx, out_data);
            step();
            cyc++;
            if (rdy) beat++;
        end
        out_ready = 1'b0;
        check("st_beats", 32'(beat), 32'd32);
        check("end_done",  32'(snap_done), 32'd1);
        check("end_busy",  32'(snap_busy), 32'd0);
        check("end_valid", 32'(out_valid), 32'd0);
        check("end_data",  out_data, 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        snap_req  = 1'b0;
        out_ready = 1'b0;
        rf[0] = 32'd0;
        for (int i = 1; i < 32; i++) rf[i] = 32'h1000_0000 + 32'(i);
        step();
        step();
        rst = 1'b0;
        check_all_zero("reset");

        // Basic sweep with address and stall-window checks
        start_snapshot(1'b0);
        run_capture();
        run_stream(1'b0, 1'b0);
        step();
        check("done_pulse_end", 32'(snap_done), 32'd0);
        check("idle_after", 32'(snap_busy), 32'd0);

        // Backpressure with a fresh pattern
        for (int i = 1; i < 32; i++) rf[i] = (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
        start_snapshot(1'b0);
        run_capture();
        run_stream(1'b1, 1'b0);
        step();

        // Write x5 during STREAM; stream must still show the captured value
        for (int i = 1; i < 32; i++) rf[i] = 32'h2000_0000 + 32'(i);
        start_snapshot(1'b0);
        run_capture();
        run_stream(1'b0, 1'b1);
        check("x5_written", rf[5], 32'hDEAD_BEEF);
        step();

        // Continuous request: two snapshots, one IDLE cycle between them
        for (int i = 1; i < 32; i++) rf[i] = 32'h3000_0000 + 32'(i * 7);
        start_snapshot(1'b1);
        run_capture();
        run_stream(1'b0, 1'b0);
        for (int i = 0; i < 32; i++) exp_rf[i] = rf[i];
        step();
        check("cont_reaccept", 32'(stall_wr), 32'd1);
        check("cont_done_gone", 32'(snap_done), 32'd0);
        run_capture();
        snap_req = 1'b0;
        run_stream(1'b0, 1'b0);
        step();
        check("cont_stays_idle", 32'(snap_busy), 32'd0);

        // Reset mid-stream at idx 10
        for (int i = 1; i < 32; i++) rf[i] = 32'h4000_0000 + 32'(i);
        start_snapshot(1'b0);
        run_capture();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) step();
        out_ready = 1'b0;
        check("rst_pre_idx", 32'(out_idx), 32'd10);
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("rst_no_done", 32'(snap_done), 32'd0);
            step();
        end
        start_snapshot(1'b0);
        run_capture();
        run_stream(1'b0, 1'b0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
